adc_pack: RTL and testbench

Framing stage on `sys_clk` that sits directly upstream of the data FIFO (`fifod`) feeding the UDP transmit path. On a start request it writes one complete frame into the FIFO: a 6-byte header, `data_len` payload bytes pulled from a valid/ready sample source, and a 1-byte checksum. It replaces raw byte fill with sequenced, self-describing frames that the host can check for loss and corruption.

---
 rtl/adc_pack_pkg.sv | 39 +++
 rtl/adc_pack_csum.sv | 25 ++
 rtl/adc_pack.sv | 151 +++++++++++++++
 tb/tb_adc_pack.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pack_pkg.sv
// Shared definitions for the adc_pack framing stage: state encoding,
// sync bytes, frame overhead and the header byte selector.
package adc_pack_pkg;

    typedef enum logic [7:0] {
        IDLE = 8'd0,
        HEAD = 8'd1,
        PAYL = 8'd2,
        CSUM = 8'd3,
        DONE = 8'd4
    } state_t;

    localparam logic [7:0]  PKT_SYNC0 = 8'h55;
    localparam logic [7:0]  PKT_SYNC1 = 8'hAA;
    localparam int unsigned FRAME_OVH = 7;

    // Header layout: sync0, sync1, part, seq, len[15:8], len[7:0].
    function automatic logic [7:0] hdr_byte(
        input logic [2:0]  idx,
        input logic [7:0]  s0,
        input logic [7:0]  s1,
        input logic [7:0]  prt,
        input logic [7:0]  seq,
        input logic [15:0] len
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = s0;
            3'd1:    b = s1;
            3'd2:    b = prt;
            3'd3:    b = seq;
            3'd4:    b = len[15:8];
            3'd5:    b = len[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/adc_pack_csum.sv
// 8-bit modulo-256 checksum accumulator with synchronous clear and enable.
module pack_csum (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [7:0] i_byte,
    output logic [7:0] o_sum
);

    logic [7:0] r_sum;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_en) begin
            r_sum <= r_sum + i_byte;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/adc_pack.sv
// Frames a valid/ready byte stream into sequenced, checksummed packets
// written straight into the downstream data FIFO.
module adc_pack
    import adc_pack_pkg::*;
#(
    parameter int unsigned MAX_LEN = 1465,
    parameter logic [7:0]  SYNC0   = PKT_SYNC0,
    parameter logic [7:0]  SYNC1   = PKT_SYNC1
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        fs,
    output logic        fd,
    output logic        err,
    input  logic [15:0] data_len,
    input  logic [7:0]  part,
    input  logic [7:0]  adc_rxd,
    input  logic        adc_rxdv,
    output logic        adc_rxrdy,
    output logic [7:0]  fifo_txd,
    output logic        fifo_txen,
    input  logic        fifo_full,
    output logic [7:0]  pkt_cnt
);

    localparam logic [15:0] LP_MAX_LEN = 16'(MAX_LEN);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_idx;
    logic [15:0] r_len;
    logic [15:0] r_cnt;
    logic [7:0]  r_part;
    logic [7:0]  r_seq;
    logic        r_err;

    logic        w_start_ok;
    logic        w_start_bad;
    logic        w_wr;
    logic        w_csum_en;
    logic [7:0]  w_txd;
    logic [7:0]  w_sum;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_wr        = 1'b0;
        w_txd       = '0;
        w_start_ok  = 1'b0;
        w_start_bad = 1'b0;
        w_csum_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (fs) begin
                    if (data_len <= LP_MAX_LEN) begin
                        w_start_ok = 1'b1;
                        w_next     = HEAD;
                    end else begin
                        w_start_bad = 1'b1;
                        w_next      = DONE;
                    end
                end
            end
            HEAD: begin
                w_wr  = ~fifo_full;
                w_txd = hdr_byte(r_idx, SYNC0, SYNC1, r_part, r_seq, r_len);
                // Sync bytes stay out of the checksum.
                w_csum_en = w_wr && (r_idx >= 3'd2);
                if (w_wr && (r_idx == 3'd5)) begin
                    w_next = (r_len == '0) ? CSUM : PAYL;
                end
            end
            PAYL: begin
                w_wr      = adc_rxdv & ~fifo_full;
                w_txd     = adc_rxd;
                w_csum_en = w_wr;
                if (w_wr && (r_cnt == 16'd1)) begin
                    w_next = CSUM;
                end
            end
            CSUM: begin
                w_wr  = ~fifo_full;
                w_txd = w_sum;
                if (w_wr) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (!fs) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_idx  <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_part <= '0;
            r_seq  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_len  <= data_len;
                r_cnt  <= data_len;
                r_part <= part;
                r_idx  <= '0;
                r_err  <= 1'b0;
            end
            if (w_start_bad) begin
                r_err <= 1'b1;
            end
            if ((r_state == HEAD) && w_wr) begin
                r_idx <= r_idx + 3'd1;
            end
            if ((r_state == PAYL) && w_wr) begin
                r_cnt <= r_cnt - 16'd1;
            end
            if ((r_state == CSUM) && w_wr) begin
                r_seq <= r_seq + 8'd1;
            end
        end
    end

    pack_csum u_csum (
        .sys_clk (sys_clk),
        .rst     (rst),
        .i_clr   (w_start_ok),
        .i_en    (w_csum_en),
        .i_byte  (w_txd),
        .o_sum   (w_sum)
    );

    assign fd        = (r_state == DONE);
    assign err       = r_err;
    assign pkt_cnt   = r_seq;
    assign adc_rxrdy = (r_state == PAYL) & ~fifo_full;
    assign fifo_txen = w_wr;
    assign fifo_txd  = w_txd;

endmodule

// File: tb/tb_adc_pack.sv
// Randomized self-checking bench for adc_pack against a frame-level byte model.
module tb_adc_pack;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        fs;
    logic        fd;
    logic        err;
    logic [15:0] data_len;
    logic [7:0]  part;
    logic [7:0]  adc_rxd;
    logic        adc_rxdv;
    logic        adc_rxrdy;
    logic [7:0]  fifo_txd;
    logic        fifo_txen;
    logic        fifo_full;
    logic [7:0]  pkt_cnt;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_full_wr = 0;
    int m_seq = 0;
    byte unsigned cap[$];
    int           cap_cyc[$];
    byte unsigned pay[$];
    byte unsigned expq[$];

    adc_pack #(.MAX_LEN(1465), .SYNC0(8'h55), .SYNC1(8'hAA)) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .fs        (fs),
        .fd        (fd),
        .err       (err),
        .data_len  (data_len),
        .part      (part),
        .adc_rxd   (adc_rxd),
        .adc_rxdv  (adc_rxdv),
        .adc_rxrdy (adc_rxrdy),
        .fifo_txd  (fifo_txd),
        .fifo_txen (fifo_txen),
        .fifo_full (fifo_full),
        .pkt_cnt   (pkt_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // Writes are captured 1 ns before each rising edge.
    always @(negedge sys_clk) begin
        #4;
        cyc++;
        if (fifo_txen === 1'b1) begin
            cap.push_back(fifo_txd);
            cap_cyc.push_back(cyc);
            if (fifo_full !== 1'b0) n_full_wr++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void build_exp(input int len, input int prt, input int seq);
        int s;
        expq.delete();
        expq.push_back(8'h55);
        expq.push_back(8'hAA);
        expq.push_back(8'(prt));
        expq.push_back(8'(seq));
        expq.push_back(8'(len / 256));
        expq.push_back(8'(len % 256));
        s = prt + seq + len / 256 + len % 256;
        for (int i = 0; i < len; i++) begin
            expq.push_back(pay[i]);
            s += pay[i];
        end
        expq.push_back(8'(s % 256));
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_fd"}, fd, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_pkt_cnt"}, pkt_cnt, 0);
        chk({tag, "_rxrdy"}, adc_rxrdy, 0);
        chk({tag, "_txen"}, fifo_txen, 0);
        chk({tag, "_txd"}, fifo_txd, 0);
    endtask

    // smode: 0 no backpressure, 1 random full, 2 full x3 at byte 2 and byte 8.
    task automatic run_frame(input int len, input int prt, input int smode,
                             input int vld_pct, input bit fixed_pay);
        int  pi = 0;
        int  st2 = 0;
        int  st8 = 0;
        int  start_c;
        int  fd_c = 0;
        bit  done = 0;
        int  nmis = 0;
        if (!fixed_pay) begin
            pay.delete();
            for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
        end
        build_exp(len, prt, m_seq);
        cap.delete();
        cap_cyc.delete();
        @(negedge sys_clk);
        fs = 1'b1;
        data_len = 16'(len);
        part = 8'(prt);
        fifo_full = 1'b0;
        adc_rxdv = 1'b0;
        start_c = cyc + 1;
        for (int k = 0; k < len * 8 + 200 && !done; k++) begin
            @(negedge sys_clk);
            data_len = 16'($urandom);
            part = 8'($urandom);
            fifo_full = 1'b0;
            if (smode == 1) fifo_full = ($urandom_range(0, 99) < 25);
            if (smode == 2) begin
                if (cap.size() == 2 && st2 < 3) begin fifo_full = 1'b1; st2++; end
                else if (cap.size() == 8 && st8 < 3) begin fifo_full = 1'b1; st8++; end
            end
            adc_rxdv = (pi < len) && ($urandom_range(0, 99) < vld_pct);
            adc_rxd = (pi < len) ? pay[pi] : 8'($urandom);
            #3;
            if (adc_rxdv && adc_rxrdy) pi++;
            if (fd) begin
                done = 1;
                fd_c = cyc + 1;
            end
        end
        chk("frame_done", done, 1);
        chk("frame_len", cap.size(), expq.size());
        for (int i = 0; i < cap.size() && i < expq.size() && nmis == 0; i++) begin
            if (cap[i] != expq[i]) nmis++;
            chk($sformatf("byte%0d", i), cap[i], expq[i]);
        end
        m_seq = (m_seq + 1) % 256;
        chk("pkt_cnt", pkt_cnt, m_seq);
        chk("err_clear", err, 0);
        if (smode == 2) chk("stall_hits", st2 + st8, 6);
        if (smode == 0 && vld_pct == 100 && cap.size() > 0) begin
            chk("first_lat", cap_cyc[0] - start_c, 1);
            chk("span", cap_cyc[cap_cyc.size() - 1] - cap_cyc[0], len + 6);
            chk("fd_lat", fd_c - cap_cyc[cap_cyc.size() - 1], 1);
        end
        @(negedge sys_clk);
        fs = 1'b0;
        adc_rxdv = 1'b0;
        fifo_full = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  nw;
        bit  hit;
        rst = 1'b1;
        fs = 1'b0;
        data_len = '0;
        part = '0;
        adc_rxd = '0;
        adc_rxdv = 1'b0;
        fifo_full = 1'b0;
        #1;
        check_reset_outputs("rst0");
        repeat (3) @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);

        // Directed frame with known bytes, then the same with stalls.
        pay = {8'h01, 8'h02, 8'h03, 8'h04};
        run_frame(4, 8'h0D, 0, 100, 1);
        chk("dir_pkt_cnt", pkt_cnt, 1);
        run_frame(4, 8'h0D, 2, 100, 1);
        run_frame(0, 8'h3C, 0, 100, 0);

        // Oversized length: flag only, nothing written.
        cap.delete();
        @(negedge sys_clk);
        fs = 1'b1;
        data_len = 16'd1466;
        part = 8'h77;
        hit = 0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge sys_clk);
            #3;
            if (fd) hit = 1;
        end
        chk("err_fd", hit, 1);
        chk("err_set", err, 1);
        chk("err_nowr", cap.size(), 0);
        chk("err_seq", pkt_cnt, m_seq);
        @(negedge sys_clk);
        fs = 1'b0;
        @(negedge sys_clk);
        #3;
        chk("err_sticky", err, 1);
        run_frame(3, 8'h11, 0, 100, 0);

        run_frame(1465, 8'hE5, 1, 70, 0);
        for (int i = 0; i < 20; i++)
            run_frame($urandom_range(0, 64), $urandom_range(0, 255), 1, $urandom_range(30, 100), 0);

        // Reset in the middle of a payload.
        pay.delete();
        cap.delete();
        @(negedge sys_clk);
        fs = 1'b1;
        data_len = 16'd32;
        part = 8'h5A;
        for (int k = 0; k < 200 && cap.size() < 12; k++) begin
            @(negedge sys_clk);
            adc_rxdv = 1'b1;
            adc_rxd = 8'($urandom);
        end
        chk("mid_reached", cap.size() >= 12, 1);
        @(negedge sys_clk);
        rst = 1'b1;
        fs = 1'b0;
        adc_rxdv = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge sys_clk);
        rst = 1'b0;
        nw = cap.size();
        repeat (10) begin
            @(negedge sys_clk);
            adc_rxdv = 1'b1;
            adc_rxd = 8'($urandom);
        end
        chk("rst_nowr", cap.size(), nw);
        adc_rxdv = 1'b0;
        m_seq = 0;

        // 257 frames: seq walks 00..FF and wraps to 00.
        for (int i = 0; i < 257; i++) begin
            run_frame($urandom_range(0, 3), $urandom_range(0, 255), 1, 80, 0);
            chk($sformatf("seq_byte%0d", i), (cap.size() > 3) ? 32'(cap[3]) : 32'hFFFF_FFFF, i % 256);
        end

        chk("no_wr_full", n_full_wr, 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
